random_hardware: RTL and testbench

Registered mixing datapath that turns a 100-bit input word into a 222-bit status/observation word every clock. It captures the input, keeps a rotate-XOR signature of the input history, counts non-zero input cycles and reports the population count of the captured word. It is a self-contained leaf block for power and activity characterisation. All outputs come straight from flops.

---
 rtl/random_hardware.sv | 54 +++++
 tb/tb_random_hardware.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/random_hardware.sv
// Registered mixing datapath: captures a 100-bit word and, every clock, reports
// a rotate-XOR signature of the input history, a non-zero-cycle count and a popcount.
module random_hardware #(
  parameter int I_WIDTH = 100,
  parameter int O_WIDTH = 222
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [I_WIDTH-1:0] io_in,
  output logic [O_WIDTH-1:0] io_out
);

  localparam int CNT_W = 15;
  localparam int POP_W = 7;

  logic [I_WIDTH-1:0] in_q, in_d;
  logic [I_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POP_W-1:0]   pop_q, pop_d;

  function automatic logic [POP_W-1:0] popcount(input logic [I_WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < I_WIDTH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    in_d  = io_in;
    sig_d = {sig_q[I_WIDTH-2:0], sig_q[I_WIDTH-1]} ^ io_in;
    // Count wraps naturally at 2^15; a zero word holds the count even at the top.
    cnt_d = (|io_in) ? cnt_q + CNT_W'(1) : cnt_q;
    pop_d = popcount(io_in);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_q  <= '0;
      sig_q <= '0;
      cnt_q <= '0;
      pop_q <= '0;
    end else begin
      in_q  <= in_d;
      sig_q <= sig_d;
      cnt_q <= cnt_d;
      pop_q <= pop_d;
    end
  end

  assign io_out = {pop_q, cnt_q, sig_q, in_q};

endmodule

// File: tb/tb_random_hardware.sv
// Bench for random_hardware: reference model checked every cycle, plus directed
// vectors with hand-computed field values.
module tb_random_hardware;

  logic         clock;
  logic         reset;
  logic [99:0]  io_in;
  logic [221:0] io_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  random_hardware #(.I_WIDTH(100), .O_WIDTH(222)) dut (
    .clock (clock),
    .reset (reset),
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: fields as plain integers / words.
  logic [99:0] m_in, m_sig;
  int          m_cnt, m_pop;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_in  <= '0;
      m_sig <= '0;
      m_cnt <= 0;
      m_pop <= 0;
    end else begin
      m_in  <= io_in;
      m_sig <= ((m_sig << 1) | (m_sig >> 99)) ^ io_in;
      m_cnt <= (io_in != '0) ? (m_cnt + 1) % 32768 : m_cnt;
      m_pop <= $countones(io_in);
    end
  end

  task automatic check(input string nm, input logic [221:0] act, input logic [221:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en)
      check("model", io_out, {7'(m_pop), 15'(m_cnt), m_sig, m_in});
  end

  // Called at a negedge; leaves the bench at a negedge with reset released.
  task automatic do_reset();
    io_in = '0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive v before the next posedge, return at the following negedge.
  task automatic apply(input logic [99:0] v);
    io_in = v;
    @(negedge clock);
  endtask

  logic [99:0] ones, bit99, mixed;

  initial begin
    ones  = '1;
    bit99 = 100'h8000000000000000000000000;
    mixed = 100'hfff600be00ff7ffff;
    io_in = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_state", io_out, 222'h0);
    @(negedge clock);
    reset = 1'b1;
    chk_en = 1;

    // Single bit, then zero
    do_reset();
    apply(100'h40);
    check("sb1_in",  222'(io_out[99:0]),    222'(100'h40));
    check("sb1_sig", 222'(io_out[199:100]), 222'(100'h40));
    check("sb1_cnt", 222'(io_out[214:200]), 222'd1);
    check("sb1_pop", 222'(io_out[221:215]), 222'd1);
    apply('0);
    check("sb2_in",  222'(io_out[99:0]),    222'd0);
    check("sb2_sig", 222'(io_out[199:100]), 222'(100'h80));
    check("sb2_cnt", 222'(io_out[214:200]), 222'd1);
    check("sb2_pop", 222'(io_out[221:215]), 222'd0);

    // Rotation wrap from bit 99 to bit 0
    do_reset();
    apply(bit99);
    check("rot1_sig", 222'(io_out[199:100]), 222'(bit99));
    apply('0);
    check("rot2_sig", 222'(io_out[199:100]), 222'd1);
    check("rot2_cnt", 222'(io_out[214:200]), 222'd1);

    // All ones twice
    do_reset();
    apply(ones);
    check("ones1_pop", 222'(io_out[221:215]), 222'd100);
    check("ones1_sig", 222'(io_out[199:100]), 222'(ones));
    check("ones1_cnt", 222'(io_out[214:200]), 222'd1);
    apply(ones);
    check("ones2_sig", 222'(io_out[199:100]), 222'd0);
    check("ones2_pop", 222'(io_out[221:215]), 222'd100);
    check("ones2_cnt", 222'(io_out[214:200]), 222'd2);

    // Mixed vector: 9 f's + 6 + b + e + 7 = 36 + 2 + 3 + 3 + 3 = 47 ones
    do_reset();
    apply(mixed);
    check("mix_in",  222'(io_out[99:0]),    222'(mixed));
    check("mix_pop", 222'(io_out[221:215]), 222'd47);
    check("mix_sig", 222'(io_out[199:100]), 222'(mixed));
    check("mix_cnt", 222'(io_out[214:200]), 222'd1);

    // Async reset between edges with non-zero state and all-ones input
    do_reset();
    apply(ones);
    apply(100'h5);
    io_in = ones;
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_immediate", io_out, 222'h0);
    @(posedge clock);
    #1 check("async_hold1", io_out, 222'h0);
    @(posedge clock);
    #1 check("async_hold2", io_out, 222'h0);
    @(negedge clock);
    reset = 1'b1;
    apply(100'h40);
    check("post_rst_sig", 222'(io_out[199:100]), 222'(100'h40));
    check("post_rst_cnt", 222'(io_out[214:200]), 222'd1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 32767; i++)
      apply({68'h0, 32'(i) + 32'd1});
    check("wrap_max", 222'(io_out[214:200]), 222'd32767);
    apply(100'h3);
    check("wrap_zero", 222'(io_out[214:200]), 222'd0);
    apply('0);
    check("wrap_hold", 222'(io_out[214:200]), 222'd0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
